// File: rtl/network_rx_link_arbiter_if.sv
// Received Ethernet beat stream after clock crossing: one beat per valid cycle,
// start/commit delimit a frame, drop aborts the frame in progress.
interface network_rx_link_arbiter_if;
  logic        valid;
  logic [63:0] data;
  logic [7:0]  keep;
  logic        start;
  logic        commit;
  logic        drop;

  modport master (output valid, data, keep, start, commit, drop);
  modport slave  (input  valid, data, keep, start, commit, drop);
endinterface

// File: rtl/network_rx_link_arbiter.sv
// Selects the SFP or baseT receive stream with debounced link qualification and frame-boundary switchover.
// Define NETWORK_RX_ARBITER_STATS_EN to implement switch_count/abort_count; otherwise both read 0.
module network_rx_link_arbiter #(
  parameter int HOLDOFF_CYCLES = 1024
) (
  input  logic                             clk_250mhz,
  input  logic                             rst_n,
  input  logic                             sfp_link_up,
  input  logic                             rgmii_link_up,
  network_rx_link_arbiter_if.slave         sfp_rx_bus,
  network_rx_link_arbiter_if.slave         rgmii_rx_bus,
  output logic                             eth_link_up,
  network_rx_link_arbiter_if.master        eth_rx_bus,
  output logic [1:0]                       active_port,
  output logic [15:0]                      switch_count,
  output logic [15:0]                      abort_count
);

  localparam int CNT_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLDOFF_VAL = CNT_W'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    ST_NONE  = 2'd0,
    ST_SFP   = 2'd1,
    ST_BASET = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic        armed_reg;
  logic        out_open_reg;
  logic        out_valid_reg;
  logic [63:0] out_data_reg;
  logic [7:0]  out_keep_reg;
  logic        out_start_reg;
  logic        out_commit_reg;
  logic        out_drop_reg;

  logic [1:0]  link_up_vec;
  logic [1:0]  qual_vec;
  logic        sfp_qual;
  logic        rgmii_qual;

  assign link_up_vec = {rgmii_link_up, sfp_link_up};

  // Index 0 = SFP, index 1 = baseT; qual is the saturated counter itself, so it drops the edge after a low sample.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_qual
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk_250mhz) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (!link_up_vec[gi]) begin
          cnt_reg <= '0;
        end else if (cnt_reg != HOLDOFF_VAL) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign qual_vec[gi] = (cnt_reg == HOLDOFF_VAL);
    end
  endgenerate

  assign sfp_qual   = qual_vec[0];
  assign rgmii_qual = qual_vec[1];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_NONE: begin
        if (sfp_qual)        state_next = ST_SFP;
        else if (rgmii_qual) state_next = ST_BASET;
      end
      ST_SFP: begin
        if (!sfp_qual) state_next = rgmii_qual ? ST_BASET : ST_NONE;
      end
      ST_BASET: begin
        if (!rgmii_qual)                    state_next = sfp_qual ? ST_SFP : ST_NONE;
        else if (sfp_qual && !out_open_reg) state_next = ST_SFP;
      end
      default: state_next = ST_NONE;
    endcase
  end

  logic        sel_valid;
  logic [63:0] sel_data;
  logic [7:0]  sel_keep;
  logic        sel_start;
  logic        sel_commit;
  logic        sel_drop;

  always_comb begin
    sel_valid  = 1'b0;
    sel_data   = '0;
    sel_keep   = '0;
    sel_start  = 1'b0;
    sel_commit = 1'b0;
    sel_drop   = 1'b0;
    if (state_reg == ST_SFP) begin
      sel_valid  = sfp_rx_bus.valid;
      sel_data   = sfp_rx_bus.data;
      sel_keep   = sfp_rx_bus.keep;
      sel_start  = sfp_rx_bus.start;
      sel_commit = sfp_rx_bus.commit;
      sel_drop   = sfp_rx_bus.drop;
    end else if (state_reg == ST_BASET) begin
      sel_valid  = rgmii_rx_bus.valid;
      sel_data   = rgmii_rx_bus.data;
      sel_keep   = rgmii_rx_bus.keep;
      sel_start  = rgmii_rx_bus.start;
      sel_commit = rgmii_rx_bus.commit;
      sel_drop   = rgmii_rx_bus.drop;
    end
  end

  logic transition;
  logic forward;

  assign transition = (state_next != state_reg);
  // Nothing is forwarded on a switch cycle; after a switch we wait for a start so no frame tail leaks out.
  assign forward    = !transition && sel_valid && (armed_reg || sel_start);

  always_ff @(posedge clk_250mhz) begin
    if (!rst_n) begin
      state_reg      <= ST_NONE;
      armed_reg      <= 1'b0;
      out_open_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_keep_reg   <= '0;
      out_start_reg  <= 1'b0;
      out_commit_reg <= 1'b0;
      out_drop_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_keep_reg   <= '0;
      out_start_reg  <= 1'b0;
      out_commit_reg <= 1'b0;
      out_drop_reg   <= 1'b0;
      if (transition) begin
        armed_reg <= 1'b0;
        if (out_open_reg) begin
          out_valid_reg <= 1'b1;
          out_drop_reg  <= 1'b1;
          out_open_reg  <= 1'b0;
        end
      end else if (forward) begin
        out_valid_reg  <= 1'b1;
        out_data_reg   <= sel_data;
        out_keep_reg   <= sel_keep;
        out_start_reg  <= sel_start;
        out_commit_reg <= sel_commit;
        out_drop_reg   <= sel_drop;
        if (sel_start) armed_reg <= 1'b1;
        if (sel_commit || sel_drop) out_open_reg <= 1'b0;
        else if (sel_start)         out_open_reg <= 1'b1;
      end
    end
  end

  assign eth_rx_bus.valid  = out_valid_reg;
  assign eth_rx_bus.data   = out_data_reg;
  assign eth_rx_bus.keep   = out_keep_reg;
  assign eth_rx_bus.start  = out_start_reg;
  assign eth_rx_bus.commit = out_commit_reg;
  assign eth_rx_bus.drop   = out_drop_reg;

  assign eth_link_up = (state_reg != ST_NONE);
  assign active_port = state_reg;

`ifdef NETWORK_RX_ARBITER_STATS_EN
  logic [15:0] switch_count_reg;
  logic [15:0] abort_count_reg;

  always_ff @(posedge clk_250mhz) begin
    if (!rst_n) begin
      switch_count_reg <= '0;
      abort_count_reg  <= '0;
    end else begin
      if (transition)                 switch_count_reg <= switch_count_reg + 16'd1;
      if (transition && out_open_reg) abort_count_reg  <= abort_count_reg + 16'd1;
    end
  end

  assign switch_count = switch_count_reg;
  assign abort_count  = abort_count_reg;
`else
  assign switch_count = '0;
  assign abort_count  = '0;
`endif

endmodule

// File: tb/tb_network_rx_link_arbiter.sv
// Scoreboard bench for network_rx_link_arbiter (HOLDOFF_CYCLES=16); stats expectations follow NETWORK_RX_ARBITER_STATS_EN.
`timescale 1ns/1ps
module tb_network_rx_link_arbiter;
  localparam int HOLDOFF = 16;
`ifdef NETWORK_RX_ARBITER_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk_250mhz = 1'b0;
  logic        rst_n;
  logic        sfp_link_up;
  logic        rgmii_link_up;
  logic        eth_link_up;
  logic [1:0]  active_port;
  logic [15:0] switch_count;
  logic [15:0] abort_count;

  network_rx_link_arbiter_if sfp_bus();
  network_rx_link_arbiter_if rgmii_bus();
  network_rx_link_arbiter_if eth_bus();

  network_rx_link_arbiter #(.HOLDOFF_CYCLES(HOLDOFF)) dut (
    .clk_250mhz    (clk_250mhz),
    .rst_n         (rst_n),
    .sfp_link_up   (sfp_link_up),
    .rgmii_link_up (rgmii_link_up),
    .sfp_rx_bus    (sfp_bus),
    .rgmii_rx_bus  (rgmii_bus),
    .eth_link_up   (eth_link_up),
    .eth_rx_bus    (eth_bus),
    .active_port   (active_port),
    .switch_count  (switch_count),
    .abort_count   (abort_count)
  );

  always #2 clk_250mhz = ~clk_250mhz;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        start;
    logic        commit;
    logic        drop;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge clk_250mhz) cyc <= cyc + 1;

  // Every valid output beat must match the head of the expected queue, including its cycle.
  always @(negedge clk_250mhz) begin
    if (eth_bus.valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat cyc=%0d got data=%h start=%b commit=%b drop=%b, required no beat",
                 cyc, eth_bus.data, eth_bus.start, eth_bus.commit, eth_bus.drop);
      end else begin
        mon_e = exp_q.pop_front();
        if (eth_bus.data !== mon_e.data || eth_bus.keep !== mon_e.keep || eth_bus.start !== mon_e.start ||
            eth_bus.commit !== mon_e.commit || eth_bus.drop !== mon_e.drop || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL beat got cyc=%0d data=%h keep=%h s/c/d=%b%b%b required cyc=%0d data=%h keep=%h s/c/d=%b%b%b",
                   cyc, eth_bus.data, eth_bus.keep, eth_bus.start, eth_bus.commit, eth_bus.drop,
                   mon_e.cyc, mon_e.data, mon_e.keep, mon_e.start, mon_e.commit, mon_e.drop);
        end else begin
          $display("beat cyc=%0d data=%h keep=%h s/c/d=%b%b%b ok", cyc, eth_bus.data, eth_bus.keep,
                   eth_bus.start, eth_bus.commit, eth_bus.drop);
        end
      end
    end
  end

  task automatic clear_buses();
    sfp_bus.valid = 1'b0;   sfp_bus.data = '0;   sfp_bus.keep = '0;
    sfp_bus.start = 1'b0;   sfp_bus.commit = 1'b0; sfp_bus.drop = 1'b0;
    rgmii_bus.valid = 1'b0; rgmii_bus.data = '0; rgmii_bus.keep = '0;
    rgmii_bus.start = 1'b0; rgmii_bus.commit = 1'b0; rgmii_bus.drop = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_250mhz);
    #1;
    clear_buses();
  endtask

  task automatic set_beat(input bit is_rgmii, input logic s, input logic c, input logic [63:0] data,
                          input logic [7:0] keep);
    if (is_rgmii) begin
      rgmii_bus.valid = 1'b1; rgmii_bus.data = data; rgmii_bus.keep = keep;
      rgmii_bus.start = s;    rgmii_bus.commit = c;  rgmii_bus.drop = 1'b0;
    end else begin
      sfp_bus.valid = 1'b1; sfp_bus.data = data; sfp_bus.keep = keep;
      sfp_bus.start = s;    sfp_bus.commit = c;  sfp_bus.drop = 1'b0;
    end
  endtask

  task automatic expect_beat(input logic s, input logic c, input logic d, input logic [63:0] data,
                             input logic [7:0] keep);
    beat_t b;
    b.cyc = cyc + 1; b.data = data; b.keep = keep; b.start = s; b.commit = c; b.drop = d;
    exp_q.push_back(b);
  endtask

  task automatic send(input bit is_rgmii, input logic s, input logic c, input logic [63:0] data,
                      input logic [7:0] keep, input bit fwd);
    set_beat(is_rgmii, s, c, data, keep);
    if (fwd) expect_beat(s, c, 1'b0, data, keep);
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sfp_link_up = 1'b0; rgmii_link_up = 1'b0;
    clear_buses();
    repeat (3) step();
    checks++;
    if (active_port !== 2'd0 || eth_link_up !== 1'b0) begin
      errors++; $display("FAIL reset_state got port=%0d link=%b required port=0 link=0", active_port, eth_link_up);
    end
    checks++;
    if (eth_bus.valid !== 1'b0 || eth_bus.data !== 64'd0) begin
      errors++; $display("FAIL reset_bus got valid=%b data=%h required 0", eth_bus.valid, eth_bus.data);
    end
    checks++;
    if (switch_count !== 16'd0 || abort_count !== 16'd0) begin
      errors++; $display("FAIL reset_stats got sw=%0d ab=%0d required 0 0", switch_count, abort_count);
    end
    $display("test_reset done");
    rst_n = 1'b1;
  endtask

  task automatic test_baset_select();
    rgmii_link_up = 1'b1;
    repeat (HOLDOFF) step();
    checks++;
    if (active_port !== 2'd0) begin
      errors++; $display("FAIL holdoff_early got port=%0d required 0", active_port);
    end
    step();
    checks++;
    if (active_port !== 2'd2 || eth_link_up !== 1'b1) begin
      errors++; $display("FAIL baset_selected got port=%0d link=%b required 2 1", active_port, eth_link_up);
    end
    checks++;
    if (switch_count !== (STATS_EN ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL switch_count_1 got %0d required %0d", switch_count, STATS_EN ? 1 : 0);
    end
    send(1'b1, 1'b0, 1'b0, 64'hDEAD_0000_0000_0001, 8'hFF, 1'b0);
    for (int i = 0; i < 8; i++)
      send(1'b1, i == 0, i == 7, 64'h0B64_0000_0000_0000 | 64'(i), 8'hFF, 1'b1);
    repeat (2) step();
    $display("test_baset_select done");
  endtask

  task automatic test_preempt();
    for (int i = 0; i < 188; i++) begin
      if (i == 20) sfp_link_up = 1'b1;
      if (i == 100) begin
        checks++;
        if (active_port !== 2'd2) begin
          errors++; $display("FAIL preempt_midframe got port=%0d required 2", active_port);
        end
      end
      send(1'b1, i == 0, i == 187, 64'h1500_0000_0000_0000 | 64'(i), (i == 187) ? 8'h0F : 8'hFF, 1'b1);
    end
    checks++;
    if (active_port !== 2'd2) begin
      errors++; $display("FAIL preempt_commit_cycle got port=%0d required 2", active_port);
    end
    step();
    checks++;
    if (active_port !== 2'd1) begin
      errors++; $display("FAIL preempt_switch got port=%0d required 1", active_port);
    end
    checks++;
    if (switch_count !== (STATS_EN ? 16'd2 : 16'd0)) begin
      errors++; $display("FAIL switch_count_2 got %0d required %0d", switch_count, STATS_EN ? 2 : 0);
    end
    $display("test_preempt done");
  endtask

  task automatic test_link_loss();
    for (int i = 0; i < 6; i++) begin
      set_beat(1'b0, i == 0, 1'b0, 64'h5F00_0000_0000_0000 | 64'(i), 8'hFF);
      expect_beat(i == 0, 1'b0, 1'b0, 64'h5F00_0000_0000_0000 | 64'(i), 8'hFF);
      set_beat(1'b1, i == 0, 1'b0, 64'hB700_0000_0000_0000 | 64'(i), 8'hFF);
      step();
    end
    sfp_link_up = 1'b0;
    set_beat(1'b0, 1'b0, 1'b0, 64'h5F00_0000_0000_0006, 8'hFF);
    expect_beat(1'b0, 1'b0, 1'b0, 64'h5F00_0000_0000_0006, 8'hFF);
    set_beat(1'b1, 1'b0, 1'b0, 64'hB700_0000_0000_0006, 8'hFF);
    step();
    checks++;
    if (active_port !== 2'd1) begin
      errors++; $display("FAIL loss_qual_cycle got port=%0d required 1", active_port);
    end
    set_beat(1'b0, 1'b0, 1'b1, 64'h5F00_0000_0000_0007, 8'hFF);
    set_beat(1'b1, 1'b0, 1'b0, 64'hB700_0000_0000_0007, 8'hFF);
    expect_beat(1'b0, 1'b0, 1'b1, 64'd0, 8'h00);
    step();
    checks++;
    if (active_port !== 2'd2 || eth_link_up !== 1'b1) begin
      errors++; $display("FAIL loss_switch got port=%0d link=%b required 2 1", active_port, eth_link_up);
    end
    checks++;
    if (abort_count !== (STATS_EN ? 16'd1 : 16'd0) || switch_count !== (STATS_EN ? 16'd3 : 16'd0)) begin
      errors++; $display("FAIL loss_stats got ab=%0d sw=%0d required ab=%0d sw=%0d", abort_count, switch_count,
                         STATS_EN ? 1 : 0, STATS_EN ? 3 : 0);
    end
    send(1'b1, 1'b0, 1'b0, 64'hB700_0000_0000_0008, 8'hFF, 1'b0);
    send(1'b1, 1'b0, 1'b1, 64'hB700_0000_0000_0009, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++)
      send(1'b1, i == 0, i == 3, 64'hB800_0000_0000_0000 | 64'(i), 8'hFF, 1'b1);
    repeat (2) step();
    $display("test_link_loss done");
  endtask

  task automatic test_flap();
    rst_n = 1'b0; sfp_link_up = 1'b0; rgmii_link_up = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i % 10 == 0) sfp_link_up = ~sfp_link_up;
      set_beat(1'b0, 1'b1, 1'b1, 64'hF1A0_0000_0000_0000 | 64'(i), 8'hFF);
      step();
      if (i % 10 == 9) begin
        checks++;
        if (active_port !== 2'd0 || eth_bus.valid !== 1'b0 || eth_bus.data !== 64'd0) begin
          errors++; $display("FAIL flap_idle i=%0d got port=%0d valid=%b required port=0 valid=0",
                             i, active_port, eth_bus.valid);
        end
      end
    end
    sfp_link_up = 1'b0;
    step();
    $display("test_flap done");
  endtask

  task automatic test_reset_mid_frame();
    rgmii_link_up = 1'b1;
    repeat (HOLDOFF + 1) step();
    checks++;
    if (active_port !== 2'd2) begin
      errors++; $display("FAIL rst_pre_select got port=%0d required 2", active_port);
    end
    for (int i = 0; i < 4; i++)
      send(1'b1, i == 0, 1'b0, 64'hAA00_0000_0000_0000 | 64'(i), 8'hFF, 1'b1);
    rst_n = 1'b0;
    set_beat(1'b1, 1'b0, 1'b0, 64'hAA00_0000_0000_0004, 8'hFF);
    step();
    checks++;
    if (eth_bus.valid !== 1'b0 || eth_bus.data !== 64'd0 || eth_bus.drop !== 1'b0 ||
        active_port !== 2'd0 || eth_link_up !== 1'b0) begin
      errors++; $display("FAIL rst_midframe got valid=%b drop=%b port=%0d link=%b required all 0",
                         eth_bus.valid, eth_bus.drop, active_port, eth_link_up);
    end
    checks++;
    if (switch_count !== 16'd0 || abort_count !== 16'd0) begin
      errors++; $display("FAIL rst_midframe_stats got sw=%0d ab=%0d required 0 0", switch_count, abort_count);
    end
    rst_n = 1'b1;
    repeat (HOLDOFF) step();
    checks++;
    if (active_port !== 2'd0) begin
      errors++; $display("FAIL requal_early got port=%0d required 0", active_port);
    end
    step();
    checks++;
    if (active_port !== 2'd2) begin
      errors++; $display("FAIL requal_select got port=%0d required 2", active_port);
    end
    $display("test_reset_mid_frame done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_buses();
    test_reset();
    test_baset_select();
    test_preempt();
    test_link_loss();
    test_flap();
    test_reset_mid_frame();
    repeat (2) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d pending beats required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
